// File: rtl/flappy_pkg.sv
// flappy_pkg: shared pipe record, default geometry and the
// pipes_controller state encoding.
package flappy_pkg;

  localparam int DEF_SCREEN_W     = 320;
  localparam int DEF_PIPE_W       = 32;
  localparam int DEF_GAP_H        = 72;
  localparam int DEF_GAP_MIN      = 32;
  localparam int DEF_BIRD_X       = 64;
  localparam int DEF_BIRD_SIZE    = 16;
  localparam int DEF_SPEED        = 2;
  localparam int DEF_SPAWN_PERIOD = 90;
  localparam int DEF_CAPACITY     = 16;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] gap_y;
  } pipe_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ITER,
    S_SPAWN,
    S_FIN
  } state_e;

endpackage

// File: rtl/pipes_controller_if.sv
// pipes_controller_if: insert and iterate ports between the
// frame scheduler (master) and the pipes_list store (slave).
interface pipes_controller_if;
  import flappy_pkg::*;

  logic  list_insert_en;
  pipe_t list_insert_data;
  logic  list_iter_start;
  logic  list_iter_done;
  pipe_t list_iter_out;
  pipe_t list_iter_in;
  logic  list_iter_remove;

  modport master (
    output list_insert_en,
    output list_insert_data,
    output list_iter_start,
    output list_iter_in,
    output list_iter_remove,
    input  list_iter_done,
    input  list_iter_out
  );

  modport slave (
    input  list_insert_en,
    input  list_insert_data,
    input  list_iter_start,
    input  list_iter_in,
    input  list_iter_remove,
    output list_iter_done,
    output list_iter_out
  );

endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11,
// advancing on every enabled cycle.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = {state_q[14:0],
               state_q[15] ^ state_q[13] ^
               state_q[12] ^ state_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pipes_controller.sv
// pipes_controller: per-frame walk of pipes_list that scrolls,
// culls, collides, scores and periodically spawns pipes.
module pipes_controller
  import flappy_pkg::*;
#(
  parameter int          SCREEN_W     = DEF_SCREEN_W,
  parameter int          PIPE_W       = DEF_PIPE_W,
  parameter int          GAP_H        = DEF_GAP_H,
  parameter int          GAP_MIN      = DEF_GAP_MIN,
  parameter int          BIRD_X       = DEF_BIRD_X,
  parameter int          BIRD_SIZE    = DEF_BIRD_SIZE,
  parameter int          SPEED        = DEF_SPEED,
  parameter int          SPAWN_PERIOD = DEF_SPAWN_PERIOD,
  parameter int          CAPACITY     = DEF_CAPACITY,
  parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       frame_tick,
  input  logic [8:0] bird_y,
  output logic       busy,
  output logic       frame_done,
  output logic       collision,
  output logic [7:0] score,
  output logic [4:0] pipe_count,
  pipes_controller_if.master list
);

  localparam int CW = $clog2(SPAWN_PERIOD);
  localparam logic [10:0] SPD = 11'(SPEED);
  localparam logic [10:0] PW  = 11'(PIPE_W);
  localparam logic [10:0] BX  = 11'(BIRD_X);
  localparam logic [10:0] BS  = 11'(BIRD_SIZE);
  localparam logic [10:0] GH  = 11'(GAP_H);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          due_q, due_d;
  logic          coll_q, coll_d;
  logic [7:0]    score_q, score_d;
  logic [4:0]    pcnt_q, pcnt_d;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [10:0] x, gy, by, xm;
  logic        tick_ok, step;
  logic        drop, hit, pass;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .state_o (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:7];

  // All geometry is compared at 11 bits so nothing wraps.
  assign x  = {1'b0, list.list_iter_out.x};
  assign gy = {2'b0, list.list_iter_out.gap_y};
  assign by = {2'b0, bird_y};
  assign xm = x - SPD;

  assign tick_ok = (state_q == S_IDLE) && frame_tick;
  assign step    = (state_q == S_ITER) && !list.list_iter_done;
  assign drop    = x < SPD;
  assign hit     = (x <= BX + BS - 11'd1) && (x + PW > BX) &&
                   ((by < gy) || (by + BS > gy + GH));
  assign pass    = (x + PW > BX) && (xm + PW <= BX) && !drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (frame_tick) state_d = S_START;
      S_START: state_d = S_ITER;
      S_ITER: begin
        if (list.list_iter_done) begin
          if (due_q && pcnt_q < 5'(CAPACITY)) state_d = S_SPAWN;
          else                                state_d = S_FIN;
        end
      end
      S_SPAWN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy                  = 1'b1;
    frame_done            = 1'b0;
    list.list_iter_start  = 1'b0;
    list.list_insert_en   = 1'b0;
    list.list_insert_data = '0;
    list.list_iter_in     = '0;
    list.list_iter_remove = 1'b0;
    unique case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: list.list_iter_start = 1'b1;
      S_ITER: begin
        if (step) begin
          if (drop) begin
            list.list_iter_remove = 1'b1;
          end else begin
            list.list_iter_in.x     = xm[9:0];
            list.list_iter_in.gap_y = list.list_iter_out.gap_y;
          end
        end
      end
      S_SPAWN: begin
        list.list_insert_en         = 1'b1;
        list.list_insert_data.x     = 10'(SCREEN_W);
        list.list_insert_data.gap_y = 9'(GAP_MIN) + {2'b0, lfsr[6:0]};
      end
      S_FIN:   frame_done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    due_d   = due_q;
    coll_d  = coll_q;
    score_d = score_q;
    pcnt_d  = pcnt_q;
    // The counter rolls over even if the list is full and the spawn is lost.
    if (tick_ok) begin
      if (cnt_q == CW'(SPAWN_PERIOD - 1)) begin
        cnt_d = '0;
        due_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        due_d = 1'b0;
      end
    end
    if (step) begin
      if (drop) pcnt_d = pcnt_q - 5'd1;
      if (hit)  coll_d = 1'b1;
      if (pass && score_q != 8'hFF) score_d = score_q + 8'd1;
    end
    if (state_q == S_SPAWN) pcnt_d = pcnt_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      due_q   <= 1'b0;
      coll_q  <= 1'b0;
      score_q <= '0;
      pcnt_q  <= '0;
    end else if (ce) begin
      cnt_q   <= cnt_d;
      due_q   <= due_d;
      coll_q  <= coll_d;
      score_q <= score_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign collision  = coll_q;
  assign score      = score_q;
  assign pipe_count = pcnt_q;

endmodule

// File: tb/tb_pipes_controller.sv
// tb_pipes_controller: directed frames against pipes_controller,
// with the bench standing in for pipes_list.
module tb_pipes_controller;
  import flappy_pkg::*;

  logic       clk = 1'b0;
  logic       rst, ce, frame_tick;
  logic [8:0] bird_y;
  logic       busy, frame_done, collision;
  logic [7:0] score;
  logic [4:0] pipe_count;

  pipes_controller_if lif ();

  pipes_controller u_dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .frame_tick (frame_tick),
    .bird_y     (bird_y),
    .busy       (busy),
    .frame_done (frame_done),
    .collision  (collision),
    .score      (score),
    .pipe_count (pipe_count),
    .list       (lif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat, ins_n, tot_ins;
  bit keep_ins;
  logic [15:0] m;
  pipe_t cur[$];
  pipe_t p;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: x^16+x^14+x^13+x^11, shift left.
  always @(posedge clk) begin
    if (rst)     m <= 16'hACE1;
    else if (ce) m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    lif.list_iter_done = 1'b1;
    lif.list_iter_out  = '0;
    cur = {};
  endtask

  task automatic frame(input int ce_at, input bit tick_mid);
    pipe_t nq[$];
    pipe_t w0;
    logic  r0;
    int    c0;
    bit    fd;
    nq = {};
    fd = 1'b0;
    ins_n = 0;
    lat = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    lif.list_iter_done = (cur.size() == 0);
    lif.list_iter_out  = (cur.size() != 0) ? cur[0] : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < cur.size(); i++) begin
      @(negedge clk);
      r0 = lif.list_iter_remove;
      w0 = lif.list_iter_in;
      if (tick_mid && i == 0) frame_tick = 1'b1;
      if (i == ce_at) begin
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("ce_busy", busy, 1);
          chk("ce_remove", lif.list_iter_remove, r0);
          chk("ce_iter_in", lif.list_iter_in, w0);
        end
        ce = 1'b1;
      end
      if (!r0) nq.push_back(w0);
      @(posedge clk);
      #1 frame_tick = 1'b0;
      if (i + 1 < cur.size()) begin
        lif.list_iter_out = cur[i+1];
      end else begin
        lif.list_iter_done = 1'b1;
        lif.list_iter_out  = '0;
      end
    end
    for (int c = 0; c < 8 && !fd; c++) begin
      @(negedge clk);
      if (lif.list_insert_en) begin
        ins_n++;
        tot_ins++;
        chk("ins_x", lif.list_insert_data.x, 320);
        chk("ins_gap", lif.list_insert_data.gap_y, 32 + m[6:0]);
        if (keep_ins) nq.push_back(lif.list_insert_data);
      end
      if (frame_done) begin
        fd = 1'b1;
        lat = cyc - c0;
      end
    end
    chk("frame_done_seen", fd, 1);
    cur = nq;
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    frame_tick = 1'b0;
    bird_y = '0;
    keep_ins = 1'b1;
    tot_ins = 0;
    lif.list_iter_done = 1'b1;
    lif.list_iter_out  = '0;
    do_rst();

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_collision", collision, 0);
    chk("rst_score", score, 0);
    chk("rst_pipe_count", pipe_count, 0);
    chk("rst_insert_en", lif.list_insert_en, 0);
    chk("rst_insert_data", lif.list_insert_data, 0);
    chk("rst_iter_start", lif.list_iter_start, 0);
    chk("rst_iter_in", lif.list_iter_in, 0);
    chk("rst_remove", lif.list_iter_remove, 0);

    // First spawn lands on tick 90.
    for (int f = 0; f < 89; f++) frame(-1, 0);
    chk("pre_spawn_inserts", tot_ins, 0);
    chk("pre_spawn_count", pipe_count, 0);
    frame(-1, 0);
    chk("spawn_inserts", ins_n, 1);
    chk("spawn_latency", lat, 4);
    chk("spawn_count", pipe_count, 1);
    chk("spawn_list_size", cur.size(), 1);

    // Scroll one pipe from x=10 down to 0, then cull it.
    p.x = 10'd10;
    p.gap_y = 9'd50;
    cur[0] = p;
    for (int f = 0; f < 5; f++) begin
      frame(-1, 0);
      chk("scroll_x", cur[0].x, 8 - 2 * f);
      chk("scroll_gap", cur[0].gap_y, 50);
    end
    frame(-1, 0);
    chk("cull_size", cur.size(), 0);
    chk("cull_count", pipe_count, 0);

    // Bird above the gap hits, and the flag is sticky.
    do_rst();
    bird_y = 9'd50;
    p.x = 10'd64;
    p.gap_y = 9'd100;
    cur.push_back(p);
    frame(-1, 0);
    chk("hit_collision", collision, 1);
    chk("hit_writeback", cur[0].x, 62);
    bird_y = 9'd110;
    frame(-1, 0);
    chk("hit_sticky", collision, 1);

    // Reset in the middle of iteration.
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    lif.list_iter_done = 1'b0;
    lif.list_iter_out  = p;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_iter_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    lif.list_iter_done = 1'b1;
    lif.list_iter_out  = '0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_remove", lif.list_iter_remove, 0);
    chk("rst_mid_iter_in", lif.list_iter_in, 0);
    chk("rst_mid_collision", collision, 0);
    chk("rst_mid_score", score, 0);

    // Bird inside the gap: no hit.
    cur = {};
    cur.push_back(p);
    frame(-1, 0);
    chk("miss_collision", collision, 0);

    // Score when the pipe's right edge crosses BIRD_X.
    do_rst();
    p.x = 10'd34;
    cur.push_back(p);
    frame(-1, 0);
    chk("score_first", score, 1);
    chk("score_x", cur[0].x, 32);
    frame(-1, 0);
    chk("score_once", score, 1);
    chk("score_nohit", collision, 0);

    // Tick ignored mid-frame and a 5-cycle ce stall inside ITER.
    do_rst();
    p.x = 10'd200; p.gap_y = 9'd50; cur.push_back(p);
    p.x = 10'd10;  p.gap_y = 9'd60; cur.push_back(p);
    p.x = 10'd5;   p.gap_y = 9'd70; cur.push_back(p);
    frame(1, 1);
    chk("stall_size", cur.size(), 3);
    chk("stall_x0", cur[0].x, 198);
    chk("stall_x1", cur[1].x, 8);
    chk("stall_x2", cur[2].x, 3);
    chk("stall_gap2", cur[2].gap_y, 70);
    repeat (6) @(negedge clk);
    chk("ignored_tick_busy", busy, 0);
    chk("ignored_tick_done", frame_done, 0);

    // Fill to capacity, drop a due spawn, check the period restarts.
    do_rst();
    bird_y = '0;
    keep_ins = 1'b0;
    tot_ins = 0;
    for (int f = 0; f < 16 * 90; f++) frame(-1, 0);
    chk("fill_inserts", tot_ins, 16);
    chk("fill_count", pipe_count, 16);
    for (int f = 0; f < 90; f++) frame(-1, 0);
    chk("full_no_insert", tot_ins, 16);
    chk("full_count", pipe_count, 16);
    p.x = 10'd0; p.gap_y = 9'd40;
    cur.push_back(p);
    frame(-1, 0);
    chk("full_cull_count", pipe_count, 15);
    for (int f = 0; f < 88; f++) frame(-1, 0);
    chk("restart_no_early", tot_ins, 16);
    frame(-1, 0);
    chk("restart_insert", ins_n, 1);
    chk("restart_count", pipe_count, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
